// File: rtl/timer_pkg.sv
// Shared encodings for the timer counting engine: FSM states, MODE values
// and the default counter width.
package timer_pkg;

    localparam int CNT_W_DFLT = 32;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_e;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Clock prescaler: asserts TICK once every PSC_DIV enabled clocks.
// CLR holds the divider at zero so every run starts on a fresh tick boundary.
module timer_prescaler #(
    parameter int PSC_DIV = 1,
    parameter int PSC_W   = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PSC_DIV - 1);

    logic [PSC_W-1:0] psc_r;

    assign TICK = EN & (psc_r == PSC_LAST);

    // Divider counter: wraps on TICK, cleared by reset or CLR.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            psc_r <= {PSC_W{1'b0}};
        end else if (CLR) begin
            psc_r <= {PSC_W{1'b0}};
        end else if (TICK) begin
            psc_r <= {PSC_W{1'b0}};
        end else if (EN) begin
            psc_r <= psc_r + PSC_W'(1);
        end else begin
            psc_r <= psc_r;
        end
    end

endmodule : timer_prescaler

// File: rtl/timer_core.sv
// Timer counting engine: runs one-shot or periodic periods from shadowed
// TOT_CNT/DUTY_CNT, producing PWM_OUT and a one-cycle IRQ_TRG at period end.
module timer_core
    import timer_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DFLT,
    parameter int PSC_DIV = 1,
    parameter int PSC_W   = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             MODE,
    input  logic             GO_EN,
    input  logic [CNT_W-1:0] TOT_CNT,
    input  logic [CNT_W-1:0] DUTY_CNT,
    output logic             IRQ_TRG,
    output logic             PWM_OUT,
    output logic             BUSY,
    output logic [CNT_W-1:0] CNT_VAL
);

    timer_state_e     state_r, state_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic [CNT_W-1:0] tot_sh_r, tot_sh_nx;
    logic [CNT_W-1:0] duty_sh_r, duty_sh_nx;
    logic             irq_r, irq_nx;
    logic             tick_s;
    logic             in_run_s;

    assign in_run_s = (state_r == ST_RUN);

    // Divider only runs inside RUN and restarts whenever the run is abandoned.
    timer_prescaler #(
        .PSC_DIV (PSC_DIV),
        .PSC_W   (PSC_W)
    ) u_psc (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .CLR    (~in_run_s | ~GO_EN),
        .EN     (in_run_s),
        .TICK   (tick_s)
    );

    // Next-state and counter decode; GO_EN low wins over a period end.
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        tot_sh_nx  = tot_sh_r;
        duty_sh_nx = duty_sh_r;
        irq_nx     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (GO_EN && (TOT_CNT != {CNT_W{1'b0}})) begin
                    tot_sh_nx  = TOT_CNT;
                    duty_sh_nx = DUTY_CNT;
                    cnt_nx     = {CNT_W{1'b0}};
                    state_nx   = ST_RUN;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!GO_EN) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = {CNT_W{1'b0}};
                end else if (tick_s) begin
                    if (cnt_r == (tot_sh_r - CNT_W'(1))) begin
                        irq_nx = 1'b1;
                        cnt_nx = {CNT_W{1'b0}};
                        if (MODE == MODE_PERIODIC) begin
                            if (TOT_CNT != {CNT_W{1'b0}}) begin
                                tot_sh_nx  = TOT_CNT;
                                duty_sh_nx = DUTY_CNT;
                                state_nx   = ST_RUN;
                            end else begin
                                state_nx = ST_IDLE;
                            end
                        end else begin
                            state_nx = ST_DONE;
                        end
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            ST_DONE: begin
                if (!GO_EN) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, shadow and interrupt registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            tot_sh_r  <= {CNT_W{1'b0}};
            duty_sh_r <= {CNT_W{1'b0}};
            irq_r     <= 1'b0;
        end else begin
            state_r   <= state_nx;
            cnt_r     <= cnt_nx;
            tot_sh_r  <= tot_sh_nx;
            duty_sh_r <= duty_sh_nx;
            irq_r     <= irq_nx;
        end
    end

    assign IRQ_TRG = irq_r;
    assign BUSY    = in_run_s;
    assign CNT_VAL = cnt_r;
    assign PWM_OUT = in_run_s & (cnt_r < duty_sh_r);

endmodule : timer_core

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: two instances (PSC_DIV=1 and 3) share
// stimulus and are compared every cycle against a tick-countdown reference model.
module tb_timer_core;

    logic        PCLK = 1'b0;
    logic        PRESET, MODE, GO_EN;
    logic [31:0] TOT_CNT, DUTY_CNT;
    logic [1:0]  irq, pwm, busy;
    logic [31:0] cval [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int irq_at0[$];
    int irq_at1[$];

    // Reference model: a run is "ticks left in period" plus a clock divider.
    localparam int DIV [2] = '{1, 3};
    bit          m_run  [2];
    bit          m_done [2];
    bit          m_irq  [2];
    int unsigned m_len  [2];
    int unsigned m_left [2];
    int unsigned m_duty [2];
    int unsigned m_div  [2];

    always #5 PCLK = ~PCLK;

    timer_core #(.CNT_W(32), .PSC_DIV(1), .PSC_W(16)) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .MODE(MODE), .GO_EN(GO_EN),
        .TOT_CNT(TOT_CNT), .DUTY_CNT(DUTY_CNT), .IRQ_TRG(irq[0]),
        .PWM_OUT(pwm[0]), .BUSY(busy[0]), .CNT_VAL(cval[0])
    );

    timer_core #(.CNT_W(32), .PSC_DIV(3), .PSC_W(16)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET), .MODE(MODE), .GO_EN(GO_EN),
        .TOT_CNT(TOT_CNT), .DUTY_CNT(DUTY_CNT), .IRQ_TRG(irq[1]),
        .PWM_OUT(pwm[1]), .BUSY(busy[1]), .CNT_VAL(cval[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            m_irq[i] = 1'b0;
            if (PRESET) begin
                m_run[i] = 1'b0; m_done[i] = 1'b0; m_len[i] = 0;
                m_left[i] = 0; m_duty[i] = 0; m_div[i] = 0;
            end else if (m_run[i]) begin
                if (!GO_EN) begin
                    m_run[i] = 1'b0; m_left[i] = 0; m_div[i] = 0;
                end else if (m_div[i] == DIV[i] - 1) begin
                    m_div[i] = 0;
                    if (m_left[i] == 1) begin
                        m_irq[i] = 1'b1;
                        if (MODE && TOT_CNT != 0) begin
                            m_len[i] = TOT_CNT; m_left[i] = TOT_CNT; m_duty[i] = DUTY_CNT;
                        end else begin
                            m_run[i]  = 1'b0;
                            m_done[i] = !MODE;
                            m_left[i] = 0;
                        end
                    end else begin
                        m_left[i] = m_left[i] - 1;
                    end
                end else begin
                    m_div[i] = m_div[i] + 1;
                end
            end else if (m_done[i]) begin
                m_done[i] = GO_EN;
            end else if (GO_EN && TOT_CNT != 0) begin
                m_run[i] = 1'b1; m_len[i] = TOT_CNT; m_left[i] = TOT_CNT;
                m_duty[i] = DUTY_CNT; m_div[i] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        int unsigned elapsed;
        for (int i = 0; i < 2; i++) begin
            elapsed = m_run[i] ? (m_len[i] - m_left[i]) : 0;
            chk($sformatf("irq[%0d]", i),  {31'd0, irq[i]},  {31'd0, m_irq[i]});
            chk($sformatf("busy[%0d]", i), {31'd0, busy[i]}, {31'd0, m_run[i]});
            chk($sformatf("cnt[%0d]", i),  cval[i],          elapsed);
            chk($sformatf("pwm[%0d]", i),  {31'd0, pwm[i]},
                {31'd0, (m_run[i] && (elapsed < m_duty[i]))});
        end
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge PCLK);
            model_update();
            #1;
            cyc++;
            if (irq[0] === 1'b1) irq_at0.push_back(cyc);
            if (irq[1] === 1'b1) irq_at1.push_back(cyc);
            check_outputs();
        end
    endtask

    task automatic start(input logic mode, input logic [31:0] tot, input logic [31:0] duty);
        MODE = mode; TOT_CNT = tot; DUTY_CNT = duty; GO_EN = 1'b1;
        cyc = 0;
        irq_at0.delete();
        irq_at1.delete();
    endtask

    task automatic stop();
        GO_EN = 1'b0;
        cycle(2);
    endtask

    initial begin
        PRESET = 1'b1; MODE = 1'b0; GO_EN = 1'b0; TOT_CNT = 32'd0; DUTY_CNT = 32'd0;
        cycle(2);
        chk("reset_cnt", cval[0], 32'd0);
        PRESET = 1'b0;
        cycle(1);

        // One-shot, 4-tick period, 2 high ticks: IRQ in cycle 5 only.
        start(1'b0, 32'd4, 32'd2);
        cycle(8);
        chk("oneshot_irq_n",   irq_at0.size(), 32'd1);
        chk("oneshot_irq_cyc", irq_at0[0],     32'd5);
        chk("oneshot_done_busy", {31'd0, busy[0]}, 32'd0);
        stop();

        // Periodic 3 then 5 (TOT_CNT changed during cycle 2).
        start(1'b1, 32'd3, 32'd1);
        cycle(2);
        TOT_CNT = 32'd5;
        cycle(8);
        chk("periodic_irq_n",  irq_at0.size(), 32'd2);
        chk("periodic_irq_c0", irq_at0[0],     32'd4);
        chk("periodic_irq_c1", irq_at0[1],     32'd9);
        stop();

        // GO_EN drops on the period-end edge: no IRQ.
        start(1'b0, 32'd2, 32'd1);
        cycle(2);
        GO_EN = 1'b0;
        cycle(3);
        chk("abort_irq_n", irq_at0.size(), 32'd0);

        // TOT_CNT=0 never starts.
        start(1'b1, 32'd0, 32'd3);
        cycle(10);
        chk("zero_irq_n", irq_at0.size() + irq_at1.size(), 32'd0);
        stop();

        // PSC_DIV=3 instance: IRQ in cycle 7, PWM high throughout.
        start(1'b0, 32'd2, 32'd5);
        cycle(9);
        chk("psc3_irq_n",   irq_at1.size(), 32'd1);
        chk("psc3_irq_cyc", irq_at1[0],     32'd7);
        stop();

        // PRESET in cycle 3 of an 8-tick run.
        start(1'b0, 32'd8, 32'd4);
        cycle(2);
        PRESET = 1'b1;
        cycle(1);
        chk("preset_busy", {31'd0, busy[0]}, 32'd0);
        PRESET = 1'b0; GO_EN = 1'b0;
        cycle(10);
        chk("preset_irq_n", irq_at0.size(), 32'd0);

        // Maximum period: counter steps without overflow.
        start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cycle(6);
        stop();

        // Randomized phase.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 6)  GO_EN    = ~GO_EN;
            if ($urandom_range(0, 99) < 20) TOT_CNT  = $urandom_range(0, 6);
            if ($urandom_range(0, 99) < 20) DUTY_CNT = $urandom_range(0, 7);
            if ($urandom_range(0, 99) < 10) MODE     = $urandom_range(0, 1);
            PRESET = ($urandom_range(0, 99) < 1);
            cycle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_timer_core
